axil_master: RTL and testbench
==============================

Name: axil_master

Overview:
- Synthesizable AXI4-Lite initiator (master). Converts single-beat commands from a simple valid/ready command port into AXI4-Lite read or write transactions, and returns data and response on a valid/ready response port.
- Drives the same register slaves the bench currently exercises with behavioural tasks, so RTL sequencers can program 0x43C0_xxxx register banks.
- One transaction outstanding at a time.

Parameters:
- ADDR_W, 32, AXI address width and cmd_addr width.
- DATA_W, 32, data width; only 32 is supported; WSTRB width is DATA_W/8.
- TIMEOUT, 1024, cycles from transaction issue to timeout flag; 0 disables the timeout.

Ports:
- clk  in  1  clock; all AXI signals are synchronous to it.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echoes cmd_write of the completed command.
- rsp_rdata  out  DATA_W  RDATA for reads; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- timeout_err  out  1  sticky flag; a transaction exceeded TIMEOUT cycles.
- AXI master ports: m_awaddr, m_awprot(3), m_awvalid, m_awready, m_wdata, m_wstrb, m_wvalid, m_wready, m_bresp(2), m_bvalid, m_bready, m_araddr, m_arprot(3), m_arvalid, m_arready, m_rdata, m_rresp(2), m_rvalid, m_rready.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All *valid, m_bready, m_rready, rsp_valid and timeout_err go to 0.
  - Address and data outputs go to 0; cmd_ready goes to 0 during reset.
  - A reset mid-transaction drops everything immediately, with no completion. The slave must also be reset.
- m_awprot and m_arprot are constant 3'b000.
- All AXI outputs are registered. There is no combinational path from any input to an AXI output.
- cmd_ready = 1 only in IDLE (registered, from state).
- IDLE:
  - On a cmd handshake, latch addr, data, strb and write.
  - Write → WR_ADDR_DATA; read → RD_ADDR.
  - The AXI valids rise on the cycle after the handshake, which is 1-cycle issue latency.
- WR_ADDR_DATA:
  - m_awvalid and m_wvalid assert together.
  - Each valid deasserts independently on the cycle after its own handshake (valid & ready sampled at posedge).
  - Address and data stay stable while their valid is high.
  - When both handshakes are complete (same cycle or different cycles, either order) → WR_RESP.
- WR_RESP:
  - m_bready = 1.
  - On m_bvalid & m_bready, capture m_bresp, set rsp_rdata = 0 and rsp_write = 1 → RSP.
- RD_ADDR:
  - m_arvalid = 1 until m_arready is sampled high, then → RD_DATA.
- RD_DATA:
  - m_rready = 1.
  - On m_rvalid & m_rready, capture m_rdata and m_rresp, set rsp_write = 0 → RSP.
- RSP:
  - rsp_valid = 1; its payload is stable until rsp_ready.
  - On rsp_ready → IDLE.
  - The next command can be accepted the cycle after the response handshake.
- No AXI valid is ever withdrawn before its handshake, so the block is protocol-checker clean.
- Timeout:
  - A counter clears on entry to WR_ADDR_DATA or RD_ADDR and increments every cycle in the AXI states.
  - When it reaches TIMEOUT, timeout_err sets and stays set until rst.
  - The transaction is not aborted; the state machine keeps waiting. The counter saturates.
- Non-zero BRESP/RRESP values are passed through unmodified and do not stop operation.
- A write followed by a read to the same address is ordered: the read is issued only after the write's B handshake.

Test Plan:
- Write with a 0-wait slave: cmd write 0x43C00004 / 0xF200000B / strb 0xF.
  - AW and W valid in the same cycle, one cycle after cmd accept.
  - rsp_valid follows, with rsp_resp = 0 and rsp_write = 1.
- Read with a 0-wait slave: read 0x43C00004 → rsp_rdata = 0xF200000B, rsp_resp = 0. Repeat for 0x43C00000, 0x43C00008 and 0x43C0000C after writing 0x1000000A and 0x3400000D.
- Skewed write handshakes: slave asserts m_wready 3 cycles before m_awready, then the reverse order.
  - Each valid drops exactly one cycle after its own handshake.
  - m_bready rises only after both handshakes.
- Backpressure:
  - Slave delays m_rvalid by 5 cycles: m_rready stays high throughout.
  - Hold rsp_ready low for 4 cycles: rsp_valid and rsp_rdata stay stable and cmd_ready stays 0.
- Error and timeout:
  - Slave returns BRESP = 2'b10: rsp_resp = 2'b10.
  - With TIMEOUT = 16, a slave that never asserts m_arready sets timeout_err at cycle 16 while m_arvalid stays high.
- Reset mid-transaction: assert rst while in WR_RESP.
  - Next cycle all valids and readies are 0 and the state is IDLE.
  - After rst deasserts, a fresh read completes normally.

Source files
------------

// File: rtl/axil_master.sv
// AXI4-Lite initiator: turns single-beat commands on a valid/ready command port
// into AXI4-Lite reads/writes, one outstanding, with a sticky timeout flag.
module axil_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                timeout_err,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [2:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; a valid, once raised, holds with stable payload until then.

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP          = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             axi_busy;
  logic             aw_done;
  logic             w_done;

  assign axi_busy  = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                     (state == RD_ADDR) || (state == RD_DATA);
  assign aw_done   = !m_awvalid || m_awready;
  assign w_done    = !m_wvalid || m_wready;
  assign m_awprot  = 3'b000;
  assign m_arprot  = 3'b000;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
      m_awaddr    <= '0;
      m_awvalid   <= 1'b0;
      m_wdata     <= '0;
      m_wstrb     <= '0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_araddr    <= '0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
    end else begin
      // Counter saturates at TIMEOUT; the flag sets on the edge it gets there.
      if (TIMEOUT > 0 && axi_busy) begin
        if (tmo_cnt != CNT_W'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
        if (tmo_cnt == CNT_W'(TIMEOUT - 1)) timeout_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            tmo_cnt   <= '0;
            if (cmd_write) begin
              m_awaddr  <= cmd_addr;
              m_wdata   <= cmd_wdata;
              m_wstrb   <= cmd_wstrb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= WR_ADDR_DATA;
            end else begin
              m_araddr  <= cmd_addr;
              m_arvalid <= 1'b1;
              state     <= RD_ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR_ADDR_DATA: begin
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready) m_wvalid <= 1'b0;
          if (aw_done && w_done) begin
            m_bready <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid && m_bready) begin
            m_bready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= m_bresp;
            state     <= RSP;
          end
        end
        RD_ADDR: begin
          if (m_arvalid && m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid && m_rready) begin
            m_rready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= m_rdata;
            rsp_resp  <= m_rresp;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: behavioural AXI4-Lite register slave with per-channel
// delays, command driver, and a response scoreboard fed from an expected queue.
module tb_axil_master;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_RESP = 3'd2;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout_err;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot, dbg_state;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [34:0] exp_q[$];  // {write, resp[1:0], rdata[31:0]}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_push(input logic w, input logic [1:0] resp, input logic [31:0] data);
    exp_q.push_back({w, resp, data});
  endtask

  // ---------------- slave model knobs ----------------
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0, rsp_hold = 0;
  bit ar_never = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] mem [0:15];

  // Slave: readies/valids change at negedge; *_pend marks a handshake that the
  // following posedge completes.
  initial begin
    bit aw_pend, w_pend, b_pend, ar_pend, r_pend;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit aw_got, w_got, ar_got, b_seen;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
    logic [3:0]  w_strb_s;
    logic [3:0]  idx;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
    aw_got = 0; w_got = 0; ar_got = 0; b_seen = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_addr_s = 0; w_data_s = 0; ar_addr_s = 0; w_strb_s = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_seen = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        continue;
      end
      aw_hs = aw_pend; w_hs = w_pend; b_hs = b_pend; ar_hs = ar_pend; r_hs = r_pend;

      if (aw_hs) begin
        m_awready = 0; aw_got = 1;
        check("awvalid_drop", 32'(m_awvalid), 0);
      end else if (m_awvalid && !m_awready && !aw_got) begin
        if (aw_cnt >= aw_delay) begin
          m_awready = 1; aw_addr_s = m_awaddr; aw_cnt = 0;
        end else aw_cnt++;
      end

      if (w_hs) begin
        m_wready = 0; w_got = 1;
        check("wvalid_drop", 32'(m_wvalid), 0);
      end else if (m_wvalid && !m_wready && !w_got) begin
        if (w_cnt >= w_delay) begin
          m_wready = 1; w_data_s = m_wdata; w_strb_s = m_wstrb; w_cnt = 0;
        end else w_cnt++;
      end

      if (m_bready && !b_seen) begin
        b_seen = 1;
        check("bready_after_aw_w", 32'(aw_got && w_got), 1);
      end

      if (b_hs) begin
        m_bvalid = 0; aw_got = 0; w_got = 0; b_seen = 0;
      end else if (aw_got && w_got && !m_bvalid) begin
        if (b_cnt >= b_delay) begin
          idx = aw_addr_s[5:2];
          for (int b = 0; b < 4; b++)
            if (w_strb_s[b]) mem[idx][8*b +: 8] = w_data_s[8*b +: 8];
          m_bvalid = 1; m_bresp = bresp_cfg; b_cnt = 0;
        end else b_cnt++;
      end

      if (ar_hs) begin
        m_arready = 0; ar_got = 1;
        check("arvalid_drop", 32'(m_arvalid), 0);
      end else if (m_arvalid && !m_arready && !ar_got && !ar_never) begin
        if (ar_cnt >= ar_delay) begin
          m_arready = 1; ar_addr_s = m_araddr; ar_cnt = 0;
        end else ar_cnt++;
      end

      if (r_hs) begin
        m_rvalid = 0; ar_got = 0;
      end else if (ar_got && !m_rvalid) begin
        check("rready_held", 32'(m_rready), 1);
        if (r_cnt >= r_delay) begin
          idx = ar_addr_s[5:2];
          m_rvalid = 1; m_rdata = mem[idx]; m_rresp = rresp_cfg; r_cnt = 0;
        end else r_cnt++;
      end

      aw_pend = m_awvalid && m_awready;
      w_pend  = m_wvalid && m_wready;
      b_pend  = m_bvalid && m_bready;
      ar_pend = m_arvalid && m_arready;
      r_pend  = m_rvalid && m_rready;
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    int hold_cnt;
    logic [31:0] hold_data;
    logic [34:0] e;
    rsp_ready = 0; hold_cnt = 0; hold_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_ready = 0; hold_cnt = 0;
      end else if (rsp_ready) begin
        rsp_ready = 0;
      end else if (rsp_valid) begin
        if (hold_cnt == 0) hold_data = rsp_rdata;
        else check("rsp_hold_rdata", rsp_rdata, hold_data);
        if (hold_cnt < rsp_hold) begin
          check("rsp_hold_cmd_ready", 32'(cmd_ready), 0);
          hold_cnt++;
        end else begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_unexpected: got write=%0d resp=%0d rdata=0x%08h expected none",
                     rsp_write, rsp_resp, rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            check("rsp_write", 32'(rsp_write), 32'(e[34]));
            check("rsp_resp", 32'(rsp_resp), 32'(e[33:32]));
            check("rsp_rdata", rsp_rdata, e[31:0]);
          end
          rsp_ready = 1;
          hold_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int cnt;
    @(negedge clk);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    cnt = 0;
    while (!cmd_ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 32'(cmd_ready), 1);
      cmd_valid = 0;
      return;
    end
    @(negedge clk);
    cmd_valid = 0;
    check("cmd_ready_busy", 32'(cmd_ready), 0);
    if (w) begin
      check("awvalid_issue", 32'(m_awvalid), 1);
      check("wvalid_issue", 32'(m_wvalid), 1);
      check("awaddr", m_awaddr, a);
      check("wdata", m_wdata, d);
      check("wstrb", 32'(m_wstrb), 32'(s));
      check("awprot", 32'(m_awprot), 0);
    end else begin
      check("arvalid_issue", 32'(m_arvalid), 1);
      check("araddr", m_araddr, a);
      check("arprot", 32'(m_arprot), 0);
    end
  endtask

  task automatic wait_done();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || rsp_valid) && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 300) check("response_timeout", 32'(exp_q.size()), 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp);
    exp_push(1'b1, resp, 32'h0);
    drive_cmd(1'b1, a, d, s);
    wait_done();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    exp_push(1'b0, resp, d);
    drive_cmd(1'b0, a, 32'h0, 4'h0);
    wait_done();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_awvalid"}, 32'(m_awvalid), 0);
    check({tag, "_wvalid"}, 32'(m_wvalid), 0);
    check({tag, "_arvalid"}, 32'(m_arvalid), 0);
    check({tag, "_bready"}, 32'(m_bready), 0);
    check({tag, "_rready"}, 32'(m_rready), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_awaddr", m_awaddr, 0);
    check("reset_wdata", m_wdata, 0);
    rst = 0;
    @(negedge clk);
    check("cmd_ready_after_reset", 32'(cmd_ready), 1);

    do_write(32'h43C0_0004, 32'hF200_000B, 4'hF, 2'b00);
    do_read(32'h43C0_0004, 32'hF200_000B, 2'b00);
    do_write(32'h43C0_0000, 32'h1000_000A, 4'hF, 2'b00);
    do_write(32'h43C0_0008, 32'h3400_000D, 4'hF, 2'b00);
    do_read(32'h43C0_0000, 32'h1000_000A, 2'b00);
    do_read(32'h43C0_0008, 32'h3400_000D, 2'b00);
    do_read(32'h43C0_000C, 32'h0000_0000, 2'b00);

    // Byte strobes 0 and 2 only.
    do_write(32'h43C0_000C, 32'hAABB_CCDD, 4'h5, 2'b00);
    do_read(32'h43C0_000C, 32'h00BB_00DD, 2'b00);

    // Skewed handshakes: W first, then AW first.
    aw_delay = 3; w_delay = 0;
    do_write(32'h43C0_0014, 32'h1234_5678, 4'hF, 2'b00);
    aw_delay = 0; w_delay = 3;
    do_write(32'h43C0_0018, 32'h9ABC_DEF0, 4'hF, 2'b00);
    w_delay = 0;

    r_delay = 5;
    do_read(32'h43C0_0014, 32'h1234_5678, 2'b00);
    r_delay = 0;

    rsp_hold = 4;
    do_read(32'h43C0_0018, 32'h9ABC_DEF0, 2'b00);
    rsp_hold = 0;

    bresp_cfg = 2'b10;
    do_write(32'h43C0_0024, 32'h5555_5555, 4'hF, 2'b10);
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b11;
    do_read(32'h43C0_0000, 32'h1000_000A, 2'b11);
    rresp_cfg = 2'b00;

    // Back-to-back write then read of the same register.
    exp_push(1'b1, 2'b00, 32'h0);
    exp_push(1'b0, 2'b00, 32'hCAFE_F00D);
    drive_cmd(1'b1, 32'h43C0_001C, 32'hCAFE_F00D, 4'hF);
    drive_cmd(1'b0, 32'h43C0_001C, 32'h0, 4'h0);
    wait_done();

    check("timeout_err_clear", 32'(timeout_err), 0);

    // Slave never accepts AR: flag rises 16 edges after issue, AR still pending.
    ar_never = 1;
    drive_cmd(1'b0, 32'h43C0_0020, 32'h0, 4'h0);
    repeat (15) @(negedge clk);
    check("timeout_before", 32'(timeout_err), 0);
    @(negedge clk);
    check("timeout_set", 32'(timeout_err), 1);
    check("timeout_arvalid", 32'(m_arvalid), 1);
    repeat (4) @(negedge clk);
    check("timeout_sticky", 32'(timeout_err), 1);
    rst = 1;
    repeat (2) @(negedge clk);
    ar_never = 0;
    rst = 0;

    // Reset while waiting for B.
    b_delay = 10;
    drive_cmd(1'b1, 32'h43C0_0010, 32'hDEAD_BEEF, 4'hF);
    cnt = 0;
    while (dbg_state != ST_WR_RESP && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("reached_wr_resp", 32'(dbg_state), 32'(ST_WR_RESP));
    rst = 1;
    @(negedge clk);
    check_quiet("midrst");
    rst = 0;
    b_delay = 0;
    do_read(32'h43C0_0004, 32'hF200_000B, 2'b00);

    repeat (5) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
